hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operands checked per issued instruction.
REQ-003 SHALL have parameter DEPTH, default 3: tracked writeback stages (stage 1 = EX, stage DEPTH = oldest); legal range 1..7.
REQ-004 SHALL have parameter LOAD_LAT, default 1: stages before load data can be forwarded; legal range 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port id_valid, input, 1: instruction present in decode.
REQ-008 SHALL have port id_src, input, NUM_SRC*REG_AW: packed source addresses; source i is bits [i*REG_AW +: REG_AW].
REQ-009 SHALL have port id_dst, input, REG_AW: decode destination address.
REQ-010 SHALL have port id_regwrite, input, 1: decode instruction writes id_dst.
REQ-011 SHALL have port id_memread, input, 1: decode instruction is a load.
REQ-012 SHALL have port flush, input, 1: invalidate all tracked stages.
REQ-013 SHALL have port fwd_sel, output, NUM_SRC*3: per-source forward select; 0 = register file, k = stage k.
REQ-014 SHALL have port stall, output, 1: hold decode and insert a bubble.
REQ-015 SHALL have port stall_cycles, output, 16: count of stalled cycles.

Function
REQ-016 SHALL hold per stage k: valid, regwrite, memread, dst, age; age counts cycles since entry.
REQ-017 SHALL shift every stage k to k+1 on every clock edge; stage DEPTH content is discarded.
REQ-018 SHALL load stage 1 from id_* when id_valid=1 and stall=0, else load a bubble (valid=0).
REQ-019 SHALL treat stage k as a match for source i when valid, regwrite, dst==src_i, and src_i!=0.
REQ-020 SHALL drive fwd_sel[i] combinationally with the lowest matching k (youngest wins), or 0 if no stage matches.
REQ-021 SHALL assert stall combinationally when id_valid=1 and any source matches a stage with memread=1 and age<LOAD_LAT.
REQ-022 SHALL keep fwd_sel[i] equal to the stage match even while stall=1; the consumer ignores it.
REQ-023 SHALL clear every stage valid on the edge where flush=1; on that same edge stage 1 receives a bubble regardless of id_valid.
REQ-024 SHALL increment stall_cycles on each edge where stall=1 and flush=0, saturating at 16'hFFFF.
REQ-025 SHALL give no forwarding or stall effect for register address 0 under any stage content.
REQ-026 SHALL, when id_dst equals a source of the same instruction, not self-match, since stage 1 holds only older instructions.

Reset
REQ-027 SHALL, on a rising edge with rst=1, clear all stage valid bits and set stall_cycles to 0; rst overrides flush and id_*.
REQ-028 SHALL, in the reset cycle and after it, read fwd_sel=0 and stall=0 until a valid write enters.

Configuration
REQ-029 SHALL have a macro HFU_LOAD_STALL_EN: defined, REQ-021 and REQ-024 apply; undefined, stall is tied 0, stall_cycles is tied 0, memread tracking is removed, and loads forward like ALU results.

Structure
REQ-030 SHALL place in shared package hfu_pkg: the stage record typedef (valid, regwrite, memread, dst, age), the FWD_RF=0 constant, and the 3-bit select width constant.
REQ-031 SHALL implement the per-source comparator/priority encoder as sub-module hfu_src_match, instantiated NUM_SRC times.

Verification
REQ-032 SHALL cover ALU back-to-back: issue write r5, then next cycle id_src0=5 -> fwd_sel[0]=1, stall=0.
REQ-033 SHALL cover double write: r7 written in two successive instructions, then read r7 -> fwd_sel=1 (youngest), not 2.
REQ-034 SHALL cover load-use with LOAD_LAT=1: load r3, then next instruction reads r3 -> stall=1 for one cycle, stall_cycles=1, then fwd_sel=2 and stall=0.
REQ-035 SHALL cover r0: write r0, then read r0 -> fwd_sel=0, stall=0.
REQ-036 SHALL cover flush: write r9, assert flush, then read r9 -> fwd_sel=0.
REQ-037 SHALL cover reset mid-stall: during load-use stall assert rst -> next cycle stall=0, stall_cycles=0, all fwd_sel=0.

Source files
------------

// File: rtl/hfu_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Build option: define HFU_LOAD_STALL_EN to enable load-use stalls and the
// stall cycle counter. Without it, loads forward like ALU results.
package hfu_pkg;

  // Width of one per-source forward select field.
  localparam int SEL_W = 3;

  // Select value meaning "take the operand from the register file".
  localparam logic [SEL_W-1:0] FWD_RF = '0;

  // Destination field width held in each stage record. The address is
  // zero-extended into it, so REG_AW must not exceed this value.
  localparam int DST_MAX_W = 16;

  // Cycles-since-entry field. Stages go up to 7, so 3 bits never wrap
  // before the entry is discarded; it saturates as a safeguard.
  localparam int AGE_W = 3;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // One tracked writeback stage.
  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memread;
    logic [DST_MAX_W-1:0] dst;
    logic [AGE_W-1:0]     age;
  } hfu_stage_t;

  // Empty stage content.
  function automatic hfu_stage_t hfu_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/hfu_src_match.sv
// Per-source comparator and priority encoder: finds the youngest stage that
// will write this source register, and flags a match on a load whose data
// is not yet available.
module hfu_src_match
  import hfu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic [REG_AW-1:0] src,
  input  hfu_stage_t        stages [DEPTH],
  output logic [SEL_W-1:0]  sel,
  output logic              load_hit
);

  logic [DST_MAX_W-1:0] src_ext;
  logic [DEPTH-1:0]     hit;

  // Match every stage, then pick the lowest stage number; r0 never matches.
  always_comb begin
    src_ext  = DST_MAX_W'(src);
    hit      = '0;
    sel      = FWD_RF;
    load_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      hit[j] = stages[j].valid && stages[j].regwrite &&
               (stages[j].dst == src_ext) && (src != '0);
      if (hit[j] && stages[j].memread &&
          (stages[j].age < AGE_W'(LOAD_LAT))) begin
        load_hit = 1'b1;
      end
    end
    // Scan oldest to youngest so the youngest match is the one that sticks.
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (hit[j]) begin
        sel = SEL_W'(j + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// Tracks DEPTH writeback stages (stage 1 = EX) and, for each decode source,
// selects the youngest in-flight producer. Build option HFU_LOAD_STALL_EN
// adds load-use stalls and the stall_cycles counter; undefined, stall and
// stall_cycles are held at 0 and loads are treated like ALU results.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,  // legal 1..7
  parameter int LOAD_LAT = 1   // legal 0..DEPTH-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [15:0]               stall_cycles
);

  // Index j holds stage j+1.
  hfu_stage_t stage_q [DEPTH];
  hfu_stage_t stage_d [DEPTH];

  logic [NUM_SRC-1:0] load_hit;
  logic               id_memread_trk;

  // Per-source match logic.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hfu_src_match #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .src      (id_src[g*REG_AW +: REG_AW]),
      .stages   (stage_q),
      .sel      (fwd_sel[g*SEL_W +: SEL_W]),
      .load_hit (load_hit[g])
    );
  end

`ifdef HFU_LOAD_STALL_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;

  assign id_memread_trk = id_memread;
  assign stall          = id_valid & (|load_hit);
  assign stall_cycles   = stall_cycles_q;

  // Count stalled cycles that are not being flushed; saturate at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !flush && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end
`else
  logic unused_load_info;

  assign id_memread_trk   = 1'b0;
  assign stall            = 1'b0;
  assign stall_cycles     = '0;
  assign unused_load_info = ^{load_hit, id_memread};
`endif

  // Next stage contents: insert decode (or a bubble) and shift everything on.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      stage_d[j] = hfu_bubble();
    end
    if (id_valid && !stall && !flush) begin
      stage_d[0].valid    = 1'b1;
      stage_d[0].regwrite = id_regwrite;
      stage_d[0].memread  = id_memread_trk;
      stage_d[0].dst      = DST_MAX_W'(id_dst);
      stage_d[0].age      = '0;
    end
    for (int j = 1; j < DEPTH; j++) begin
      stage_d[j] = stage_q[j-1];
      if (stage_q[j-1].age != AGE_MAX) begin
        stage_d[j].age = stage_q[j-1].age + 1'b1;
      end
      if (flush) begin
        stage_d[j].valid = 1'b0;
      end
    end
  end

  // Stage register; reset empties every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_q[j] <= hfu_bubble();
      end
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a history-of-instructions model
// checked against the DUT every cycle, plus hand-computed spot checks.
module tb_hazard_forward_unit;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
`ifdef HFU_LOAD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_regwrite;
  logic                      id_memread;
  logic                      flush;
  logic [NUM_SRC*3-1:0]      fwd_sel;
  logic                      stall;
  logic [15:0]               stall_cycles;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // hist[0] is the instruction issued one cycle ago, hist[k] k+1 cycles ago.
  typedef struct {
    bit v;
    bit rw;
    bit mr;
    int dst;
  } ins_t;

  ins_t hist [$];
  int   m_cnt   = 0;
  bit   started = 1'b0;

  function automatic int src_of(int i);
    logic [NUM_SRC*REG_AW-1:0] s;
    s = id_src;
    return int'(s[i*REG_AW +: REG_AW]);
  endfunction

  function automatic int model_sel(int src);
    if (src == 0) return 0;
    for (int k = 0; k < DEPTH; k++)
      if (hist[k].v && hist[k].rw && hist[k].dst == src) return k + 1;
    return 0;
  endfunction

  // A load issued k+1 cycles ago has spent k cycles in the pipe.
  function automatic bit model_stall();
    if (!STALL_EN || !id_valid) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int s;
      s = src_of(i);
      if (s == 0) continue;
      for (int k = 0; k < DEPTH; k++)
        if (hist[k].v && hist[k].rw && hist[k].mr && hist[k].dst == s &&
            k < LOAD_LAT) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int k = 0; k < DEPTH; k++) hist.push_back('{0, 0, 0, 0});
      m_cnt   = 0;
      started = 1'b1;
    end else if (started) begin
      bit   s;
      ins_t n;
      s = model_stall();
      if (s && !flush && m_cnt < 65535) m_cnt++;
      n = '{0, 0, 0, 0};
      if (id_valid && !s && !flush)
        n = '{1, id_regwrite, id_memread, int'(id_dst)};
      hist.push_front(n);
      void'(hist.pop_back());
      if (flush)
        for (int k = 0; k < DEPTH; k++) hist[k].v = 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NUM_SRC; i++)
        check($sformatf("cyc_fwd_sel%0d", i), int'(fwd_sel[i*3 +: 3]),
              model_sel(src_of(i)));
      check("cyc_stall", int'(stall), int'(model_stall()));
      check("cyc_stall_cycles", int'(stall_cycles), m_cnt);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int s0, input int s1, input int dst,
                       input bit rw, input bit mr, input bit fl);
    id_valid    = v;
    id_src      = {REG_AW'(s1), REG_AW'(s0)};
    id_dst      = REG_AW'(dst);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    check("reset_fwd", int'(fwd_sel), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_cnt", int'(stall_cycles), 0);

    // ALU back-to-back: write r5, then read r5.
    drive(1, 0, 0, 5, 1, 0, 0); cyc();
    drive(1, 5, 0, 0, 0, 0, 0); settle();
    check("b2b_fwd0", int'(fwd_sel[2:0]), 1);
    check("b2b_stall", int'(stall), 0);
    cyc(); idle(); cyc(); cyc(); cyc();

    // Double write of r7: youngest wins.
    drive(1, 0, 0, 7, 1, 0, 0); cyc();
    drive(1, 0, 0, 7, 1, 0, 0); cyc();
    drive(1, 0, 7, 0, 0, 0, 0); settle();
    check("dbl_fwd1", int'(fwd_sel[5:3]), 1);
    cyc(); idle(); cyc(); cyc(); cyc();

    // Load-use on r3.
    drive(1, 0, 0, 3, 1, 1, 0); cyc();
    drive(1, 3, 0, 0, 0, 0, 0); settle();
    check("lu_stall", int'(stall), STALL_EN ? 1 : 0);
    check("lu_fwd_first", int'(fwd_sel[2:0]), 1);
    cyc(); settle();
    check("lu_stall_after", int'(stall), 0);
    check("lu_fwd_after", int'(fwd_sel[2:0]), 2);
    check("lu_cnt", int'(stall_cycles), STALL_EN ? 1 : 0);
    cyc(); idle(); cyc(); cyc(); cyc();

    // r0 never forwards or stalls, even from a load.
    drive(1, 0, 0, 0, 1, 1, 0); cyc();
    drive(1, 0, 0, 0, 0, 0, 0); settle();
    check("r0_fwd", int'(fwd_sel), 0);
    check("r0_stall", int'(stall), 0);
    cyc(); idle(); cyc(); cyc(); cyc();

    // Self-match: an instruction reading its own destination.
    drive(1, 6, 0, 6, 1, 0, 0); settle();
    check("self_fwd", int'(fwd_sel[2:0]), 0);
    cyc();
    drive(1, 6, 6, 0, 0, 0, 0); settle();
    check("self_next_fwd", int'(fwd_sel), 9);
    cyc(); idle(); cyc(); cyc(); cyc();

    // Oldest stage boundary: r10 three cycles back forwards from stage 3.
    drive(1, 0, 0, 10, 1, 0, 0); cyc();
    idle(); cyc(); cyc();
    drive(1, 10, 0, 0, 0, 0, 0); settle();
    check("deep_fwd3", int'(fwd_sel[2:0]), 3);
    cyc(); settle();
    check("deep_gone", int'(fwd_sel[2:0]), 0);
    idle(); cyc(); cyc(); cyc();

    // Flush after a write of r9.
    drive(1, 0, 0, 9, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 9, 9, 0, 0, 0, 0); settle();
    check("flush_fwd", int'(fwd_sel), 0);
    cyc();
    // Flush on the same edge as a valid write: the write is dropped.
    drive(1, 0, 0, 9, 1, 0, 1); cyc();
    drive(1, 9, 0, 0, 0, 0, 0); settle();
    check("flush_same_edge", int'(fwd_sel[2:0]), 0);
    cyc(); idle(); cyc(); cyc(); cyc();

    // Reset in the middle of a load-use stall.
    drive(1, 0, 0, 4, 1, 1, 0); cyc();
    drive(1, 0, 4, 0, 0, 0, 0); settle();
    check("rs_stall_before", int'(stall), STALL_EN ? 1 : 0);
    check("rs_cnt_before", int'(stall_cycles), STALL_EN ? 1 : 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("rs_stall_after", int'(stall), 0);
    check("rs_cnt_after", int'(stall_cycles), 0);
    check("rs_fwd_after", int'(fwd_sel), 0);
    cyc(); idle(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
